// File: rtl/flash_adc_sequencer.sv
// Sequencer for the on-chip flash ADC: warm-up, settle, strobe and capture, then
// bubble-correct, encode and average samples, delivering results over valid/ready.
module flash_adc_sequencer #(
  parameter int BITS     = 4,
  parameter int AVG_LOG2 = 2,
  parameter int WARMUP   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 continuous,
  input  logic [3:0]           cfg_settle,
  input  logic [2**BITS-2:0]   cmp_thermo,
  output logic                 adc_en,
  output logic                 adc_sample,
  output logic [BITS-1:0]      res_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int N      = 2**BITS - 1;
  localparam int NSAMP  = 2**AVG_LOG2;
  localparam int ACC_W  = BITS + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int TMR_W  = ($clog2(WARMUP + 1) > 4) ? $clog2(WARMUP + 1) : 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_SETTLE,
    ST_STROBE,
    ST_CAPTURE
  } state_t;

  state_t            state, state_d;
  logic [3:0]        s_lat;
  logic [TMR_W-1:0]  tmr;
  logic [CNT_W-1:0]  sample_cnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [N+1:0]      ext;
  logic [N-1:0]      corr;
  logic [BITS-1:0]   code;
  logic              last_sample;
  logic              accept;

  // Thermometer padded with an implied always-tripped comparator below bit 0
  // and an implied never-tripped one above the top bit.
  assign ext = {1'b0, cmp_thermo, 1'b1};

  // NOTE: every signal driven from always_comb gets a default before any
  // branching, otherwise an unassigned path infers a latch.
  always_comb begin
    corr = '0;
    code = '0;
    for (int i = 0; i < N; i++) begin
      corr[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
      code    = code + BITS'(corr[i]);
    end
  end

  assign acc_sum     = acc + ACC_W'(code);
  assign last_sample = (sample_cnt == CNT_W'(NSAMP - 1));
  assign accept      = res_valid & res_ready;

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:    if (start) state_d = ST_WARMUP;
      ST_WARMUP:  if (tmr == '0) state_d = ST_SETTLE;
      ST_SETTLE:  if (tmr == '0) state_d = ST_STROBE;
      ST_STROBE:  state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (!last_sample || continuous) state_d = ST_SETTLE;
        else                            state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      s_lat      <= '0;
      tmr        <= '0;
      sample_cnt <= '0;
      acc        <= '0;
      adc_en     <= 1'b0;
      adc_sample <= 1'b0;
      busy       <= 1'b0;
      res_data   <= '0;
      res_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_d;
      // Strobe and enable are decoded from the next state so they line up
      // with the state they belong to, with no combinational output path.
      adc_en     <= (state_d != ST_IDLE);
      adc_sample <= (state_d == ST_STROBE);
      busy       <= (state_d != ST_IDLE);

      if (accept) res_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            s_lat      <= cfg_settle;
            tmr        <= TMR_W'(WARMUP - 1);
            acc        <= '0;
            sample_cnt <= '0;
            overrun    <= 1'b0;
          end
        end
        ST_WARMUP: begin
          if (tmr == '0) tmr <= TMR_W'(s_lat);
          else           tmr <= tmr - 1'b1;
        end
        ST_SETTLE: begin
          if (tmr != '0) tmr <= tmr - 1'b1;
        end
        ST_CAPTURE: begin
          tmr <= TMR_W'(s_lat);
          if (last_sample) begin
            acc        <= '0;
            sample_cnt <= '0;
            res_data   <= acc_sum[ACC_W-1:AVG_LOG2];
            res_valid  <= 1'b1;
            // A same-edge accept frees the slot, so only a stalled result counts.
            if (res_valid && !res_ready) overrun <= 1'b1;
          end else begin
            acc        <= acc_sum;
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/flash_adc_sequencer.md
Name: flash_adc_sequencer

Overview:
Digital controller that sequences the on-chip flash ADC macro. It enables the comparator bias, waits a warm-up and a per-sample settle time, and strobes the comparator latch. It captures the thermometer code, bubble-corrects and encodes it, then averages 2^AVG_LOG2 samples. Results are delivered over a valid/ready interface in single-shot or continuous mode.

Parameters:
BITS, 4, ADC resolution; the comparator bank is 2^BITS-1 wide (15 by default).
AVG_LOG2, 2, log2 of the number of samples averaged per result.
WARMUP, 2, number of cycles adc_en is high before the first settle window of a run.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  begin a run; honoured only in IDLE
continuous  in  1  1 = free-running; 0 = single result. Sampled at every result publish.
cfg_settle  in  4  settle length S; the settle window is S+1 cycles. Latched at start.
cmp_thermo  in  2^BITS-1  comparator outputs; bit0 = lowest threshold
adc_en  out  1  comparator bias enable
adc_sample  out  1  comparator latch strobe
res_data  out  BITS  averaged result
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
overrun  out  1  sticky: an unconsumed result was overwritten
busy  out  1  FSM not in IDLE

Behaviour:
- Reset:
  - Synchronous: rst high at an edge forces IDLE and clears all outputs to 0, the accumulator, the sample counter and the latched S.
  - Reset overrides every other input, including mid-run.
- States: IDLE, WARMUP, SETTLE, STROBE, CAPTURE.
- Transitions:
  - IDLE, start=1: go to WARMUP, latch S, clear accumulator/counter, clear overrun. start in any other state is ignored.
  - WARMUP: lasts WARMUP cycles, then SETTLE.
  - SETTLE: lasts S+1 cycles, then STROBE.
  - STROBE: 1 cycle, then CAPTURE.
  - CAPTURE: 1 cycle; cmp_thermo is registered at the closing edge.
  - After CAPTURE, if samples taken < 2^AVG_LOG2: go to SETTLE.
  - After CAPTURE, otherwise: publish the result. Then continuous=1 goes to SETTLE (no WARMUP); continuous=0 goes to IDLE.
- Outputs per state:
  - adc_en=1 in every state except IDLE.
  - adc_sample=1 only in STROBE.
  - busy=1 whenever the state is not IDLE.
- Bubble correction: c[i] = majority(t[i-1], t[i], t[i+1]), with t[-1]=1 and t[2^BITS-1]=0.
- Encoding: code = popcount(c), range 0..2^BITS-1.
- Accumulator: BITS+AVG_LOG2 bits wide; cannot overflow.
- Result: res_data = acc >> AVG_LOG2, truncating. The accumulator and counter are cleared at publish.
- Timing:
  - Sample period = S+3 cycles.
  - For a start sampled at edge E0, res_valid rises at edge E0 + WARMUP + 2^AVG_LOG2*(S+3).
- Handshake:
  - res_valid and res_data hold until res_valid & res_ready at an edge, which clears res_valid.
  - Publish while res_valid=1 and res_ready=0: overwrite res_data, keep res_valid=1, set overrun.
  - Publish in the same cycle as an accept: load the new value, res_valid stays 1, no overrun.
  - overrun clears only on rst or an accepted start.
- Stopping continuous mode: deasserting continuous finishes the current average, publishes it, then goes to IDLE.
- A result published before a later reset is lost on reset.

Test Plan:
1. Defaults, S=1, cmp_thermo=0x7FFF constant, single-shot:
   - res_valid rises 18 cycles after the start edge with res_data=15.
   - adc_sample pulses exactly 4 times, each 1 cycle, 4 cycles apart.
   - adc_en falls on return to IDLE.
2. Bubble correction, cmp_thermo=0x0FF7 (bit3 bubble) held: res_data=12, not the raw popcount of 11.
3. Averaging: per-sample codes 4,5,5,6 (thermo 0x000F, 0x001F, 0x001F, 0x003F) -> res_data=5, i.e. 20>>2.
4. Continuous mode, res_ready held 0:
   - Second publish overwrites res_data, overrun=1, res_valid stays 1.
   - Next start clears overrun.
   - Consecutive res_valid-ready events are 16 cycles apart with no WARMUP between results.
5. Accept/publish collision: res_ready=1 on the publish edge while a previous result is valid -> new value loaded, res_valid=1, overrun=0.
6. rst pulsed during SETTLE of the 3rd sample:
   - Next cycle is IDLE with all outputs 0.
   - A fresh start produces a full 4-sample result and does not reuse the partial accumulator.
